// File: rtl/time_pkg.sv
// Shared constants and types for the cascaded time counters
// (seconds, minutes, hours, days, months).
package time_pkg;

    // Typical runtime limits for each stage of a calendar/clock chain.
    localparam int SEC_MAX   = 59;
    localparam int MIN_MAX   = 59;
    localparam int HOUR_MAX  = 23;
    localparam int MONTH_MAX = 12;
    localparam int DAY_MIN   = 1;

    // What the counter does in a given cycle.
    typedef enum logic [2:0] {
        STEP_HOLD    = 3'd0,
        STEP_LOAD    = 3'd1,
        STEP_REJECT  = 3'd2,
        STEP_INC     = 3'd3,
        STEP_WRAP_UP = 3'd4,
        STEP_DEC     = 3'd5,
        STEP_WRAP_DN = 3'd6,
        STEP_CLAMP   = 3'd7
    } step_e;

endpackage

// File: rtl/time_counter_if.sv
// Bus bundle of one time_counter stage. The master drives control/data,
// the slave (the counter) drives count, databus, carry and load_err.
// With TIME_COUNTER_BCD_EN defined the bundle also carries bcd[7:0].
interface time_counter_if #(
    parameter int WIDTH = 6
);
    import time_pkg::*;

    logic             load;
    logic             tick;
    logic             up_dn;
    logic             oe;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] databus;
    logic             carry;
    logic             load_err;
`ifdef TIME_COUNTER_BCD_EN
    logic [7:0]       bcd;

    modport master (
        output load, tick, up_dn, oe, data, limit,
        input  count, databus, carry, load_err, bcd
    );
    modport slave (
        input  load, tick, up_dn, oe, data, limit,
        output count, databus, carry, load_err, bcd
    );
`else
    modport master (
        output load, tick, up_dn, oe, data, limit,
        input  count, databus, carry, load_err
    );
    modport slave (
        input  load, tick, up_dn, oe, data, limit,
        output count, databus, carry, load_err
    );
`endif

endinterface

// File: rtl/time_counter_bin2bcd.sv
// Combinational binary to two-digit BCD conversion, valid for 0..99.
// Exists only when TIME_COUNTER_BCD_EN is defined.
`ifdef TIME_COUNTER_BCD_EN
module bin2bcd #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [7:0]       bcd_o
);
    logic [15:0] bin_ext_s;
    logic [15:0] tens_s;
    logic [15:0] ones_s;

    // Divide by ten: constant divisors keep this a small fixed network.
    always_comb begin
        bin_ext_s = 16'(bin_i);
        tens_s    = bin_ext_s / 16'd10;
        ones_s    = bin_ext_s % 16'd10;
        bcd_o     = {tens_s[3:0], ones_s[3:0]};
    end

endmodule
`endif

// File: rtl/time_counter.sv
// Loadable up/down wrap counter with runtime limit, one stage of a
// seconds/minutes/hours/days chain. carry is a one-cycle registered pulse
// usable directly as the next stage's tick.
// Optional feature macro: TIME_COUNTER_BCD_EN adds a registered bcd image.
module time_counter
    import time_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int MIN_VAL = 0,
    parameter int RST_VAL = MIN_VAL
) (
    input  logic                 clk,
    input  logic                 clear_n,
    time_counter_if.slave        bus
);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);

    // v >= MIN_VAL, phrased so a zero MIN_VAL is not a constant compare.
    function automatic logic ge_min(input logic [WIDTH-1:0] v);
        return (({1'b0, v} + ONE_X) > {1'b0, MIN_W});
    endfunction

    // v <= MIN_VAL, phrased the same way.
    function automatic logic le_min(input logic [WIDTH-1:0] v);
        return ({1'b0, v} < ({1'b0, MIN_W} + ONE_X));
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH-1:0] lim_s;
    logic             lim_low_s;
    step_e            step_s;

    // Effective limit: a limit below MIN_VAL behaves as MIN_VAL.
    always_comb begin
        lim_low_s = !ge_min(bus.limit);
        if (lim_low_s) begin
            lim_s = MIN_W;
        end else begin
            lim_s = bus.limit;
        end
    end

    // Decide this cycle's action: load beats tick beats hold.
    always_comb begin
        step_s = STEP_HOLD;
        if (bus.load) begin
            if (ge_min(bus.data) && (bus.data <= lim_s)) begin
                step_s = STEP_LOAD;
            end else begin
                step_s = STEP_REJECT;
            end
        end else if (bus.tick) begin
            if (lim_low_s) begin
                step_s = STEP_WRAP_UP;
            end else if (bus.up_dn) begin
                // Wrap test comes first, so count+1 never overflows.
                if (count_q >= lim_s) begin
                    step_s = STEP_WRAP_UP;
                end else begin
                    step_s = STEP_INC;
                end
            end else if (le_min(count_q)) begin
                step_s = STEP_WRAP_DN;
            end else if (count_q > lim_s) begin
                step_s = STEP_CLAMP;
            end else begin
                step_s = STEP_DEC;
            end
        end else begin
            step_s = STEP_HOLD;
        end
    end

    // Next count and pulse values for the chosen action.
    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        case (step_s)
            STEP_LOAD:    count_d = bus.data;
            STEP_REJECT:  load_err_d = 1'b1;
            STEP_INC:     count_d = count_q + WIDTH'(1);
            STEP_WRAP_UP: begin
                count_d = MIN_W;
                carry_d = 1'b1;
            end
            STEP_DEC:     count_d = count_q - WIDTH'(1);
            STEP_WRAP_DN: begin
                count_d = lim_s;
                carry_d = 1'b1;
            end
            STEP_CLAMP:   count_d = lim_s;
            default:      count_d = count_q;
        endcase
    end

    // State and pulse registers, synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count_q    <= RST_W;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.carry    = carry_q;
    assign bus.load_err = load_err_q;
    assign bus.databus  = count_q & {WIDTH{bus.oe}};

`ifdef TIME_COUNTER_BCD_EN
    logic [7:0] bcd_d;
    logic [7:0] bcd_q;

    bin2bcd #(.WIDTH(WIDTH)) u_bin2bcd (
        .bin_i (count_d),
        .bcd_o (bcd_d)
    );

    // BCD image registered alongside count; cleared to zero on reset.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            bcd_q <= 8'h00;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bus.bcd = bcd_q;
`endif

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The module SHALL take parameter WIDTH, default 6: bit width of count, data, limit and databus.
REQ-002 The module SHALL take parameter MIN_VAL, default 0: lowest count value (1 for day/month use).
REQ-003 The module SHALL take parameter RST_VAL, default MIN_VAL: value loaded on reset.
REQ-004 The module SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port clear_n, input, 1: reset, synchronous and active-low.
REQ-006 The module SHALL have port load, input, 1: load data into count.
REQ-007 The module SHALL have port tick, input, 1: advance count by one step.
REQ-008 The module SHALL have port up_dn, input, 1: direction, 1 = up, 0 = down.
REQ-009 The module SHALL have port oe, input, 1: databus output enable.
REQ-010 The module SHALL have port data, input, WIDTH: load value.
REQ-011 The module SHALL have port limit, input, WIDTH: runtime maximum count value, e.g. 23, 59, or 28..31 for days.
REQ-012 The module SHALL have port count, output, WIDTH: registered counter value.
REQ-013 The module SHALL have port databus, output, WIDTH: count when oe=1, else all zeros; combinational AND gating.
REQ-014 The module SHALL have port carry, output, 1: registered one-cycle pulse on any wrap, up or down.
REQ-015 The module SHALL have port load_err, output, 1: registered one-cycle pulse on a rejected load.

Function
REQ-016 Each cycle SHALL apply this priority: clear_n low, then load, then tick, then hold.
REQ-017 A load with MIN_VAL <= data <= limit SHALL set count=data next cycle; carry=0.
REQ-018 A load with data outside [MIN_VAL, limit] SHALL leave count unchanged and pulse load_err=1 for one cycle.
REQ-019 For tick with up_dn=1 and count < limit, count SHALL become count+1 and carry=0.
REQ-020 For tick with up_dn=1 and count >= limit, count SHALL become MIN_VAL and carry=1 for one cycle; this covers a stale count above a newly reduced limit.
REQ-021 For tick with up_dn=0 and MIN_VAL < count <= limit, count SHALL become count-1 and carry=0.
REQ-022 For tick with up_dn=0 and count <= MIN_VAL, count SHALL become limit and carry=1 for one cycle.
REQ-023 For tick with up_dn=0 and count > limit, count SHALL become limit and carry=0 (clamp).
REQ-024 When load and tick are both high, load SHALL win; no step and no carry.
REQ-025 Without tick or load, count SHALL hold even if limit changes; carry=0 and load_err=0.
REQ-026 Arithmetic SHALL be WIDTH bits unsigned; no intermediate overflow is permitted because wrap precedes the increment.
REQ-027 If limit < MIN_VAL, the block SHALL treat limit as MIN_VAL; every tick then yields count=MIN_VAL with carry=1.
REQ-028 carry SHALL be sized so the next stage can use it directly as its tick (cascade: seconds, minutes, hours, days).

Reset
REQ-029 While clear_n=0 at a clock edge, the block SHALL set count=RST_VAL, carry=0, load_err=0 and bcd=0; reset overrides load and tick.
REQ-030 Reset asserted mid-sequence SHALL discard any pending step; the first tick after release SHALL step from RST_VAL.

Configuration
REQ-031 With TIME_COUNTER_BCD_EN defined, the block SHALL add output bcd[7:0]: a registered two-digit BCD image of count, updated in the same cycle as count and valid for count 0..99.
REQ-032 Without TIME_COUNTER_BCD_EN, no bcd port and no conversion logic SHALL exist; all other behaviour is identical.

Structure
REQ-033 Shared package time_pkg SHALL hold the limit constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12 and DAY_MIN=1.
REQ-034 Sub-module bin2bcd SHALL hold the combinational binary-to-BCD conversion, instantiated only under TIME_COUNTER_BCD_EN.

Verification
REQ-035 Bench SHALL check: limit=23, up, 25 ticks from reset 0 -> count 0..23, 0, 1; carry high exactly in the cycle count shows 0 after 23.
REQ-036 Bench SHALL check: MIN_VAL=1, limit=28, load 31 -> load_err pulse, count unchanged; load 28 then tick -> count=1, carry=1.
REQ-037 Bench SHALL check: count=30, limit changed to 28, tick up -> count=1, carry=1; tick down from 30 -> count=28, carry=0.
REQ-038 Bench SHALL check: down mode, limit=59, count=0, tick -> count=59, carry=1.
REQ-039 Bench SHALL check: load=1 and tick=1 with data=10 -> count=10, no carry; clear_n=0 with load=1 -> count=RST_VAL.
REQ-040 Bench SHALL check: oe toggled with count=17 -> databus 17/0 in the same cycle; with TIME_COUNTER_BCD_EN defined, bcd=8'h17.
